// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter
//   Round-robin arbiter that shares one 4-phase req/ack CDC sender among
//   NUM_REQ source-domain requesters. The granted payload is latched into
//   tx_data/tx_src on the grant edge and held until the next grant, so the
//   receiver domain always samples a quiet bus.
//
// Ports
//   clk, reset        source clock, synchronous active-high reset
//   req_valid/data    per-requester request level and packed payloads
//   req_grant         one-hot grant pulse (combinational, payload captured)
//   req_done          one-hot pulse when that requester's handshake ends
//   snd_ready/ctrl    sender idle level / synchronized-ack pulse
//   snd_start         start strobe to the sender (high only in START)
//   tx_data/tx_src    payload and owner index toward the receiver domain
//   busy              FSM not in IDLE
//   err_timeout       sticky watchdog error
//
// Optional build macro: CDC_TX_ARB_TIMEOUT_EN enables the handshake watchdog
// (TIMEOUT_CYC cycles). Without it err_timeout is tied low and the FSM waits
// indefinitely for the sender.

module cdc_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1023,
  localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic [NUM_REQ-1:0]        req_done,
  input  logic                      snd_ready,
  input  logic                      snd_ctrl,
  output logic                      snd_start,
  output logic [DATA_W-1:0]         tx_data,
  output logic [SRC_W-1:0]          tx_src,
  output logic                      busy,
  output logic                      err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_IDLE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]    tx_src_q, tx_src_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                done_q, done_d;
  logic [SRC_W-1:0]    winner;
  logic                found;
  logic                grant_en;
  logic                timeout_hit;

  // Unpacked per-lane view of the packed payload bus.
  logic [DATA_W-1:0]   lane_data [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_data[g] = req_data[g*DATA_W +: DATA_W];
  end

  // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[SRC_W'(idx)]) begin
        found  = 1'b1;
        winner = SRC_W'(idx);
      end
    end
  end

  // No grant in the req_done cycle: the next owner is picked the cycle after.
  assign grant_en = (state_q == S_IDLE) && !done_q && snd_ready && found;

  always_comb begin
    req_grant = '0;
    if (grant_en) req_grant[winner] = 1'b1;
  end

  always_comb begin
    req_done = '0;
    if (done_q) req_done[tx_src_q] = 1'b1;
  end

`ifdef CDC_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout_hit = (state_q != S_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC));

  // START is only entered from IDLE, so clearing in IDLE clears on entry.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE)  cnt_d = '0;
    else if (!timeout_hit)  cnt_d = cnt_q + CNT_W'(1);
    err_d = err_q | timeout_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
  assign err_timeout        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    tx_src_d  = tx_src_q;
    tx_data_d = tx_data_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          tx_data_d = lane_data[winner];
          tx_src_d  = winner;
          rr_ptr_d  = (int'(winner) == NUM_REQ - 1) ? '0 : winner + SRC_W'(1);
          state_d   = S_START;
        end
      end
      S_START: begin
        // Sender dropping ready means it has taken the start.
        if (timeout_hit)     state_d = S_IDLE;
        else if (!snd_ready) state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (timeout_hit)   state_d = S_IDLE;
        else if (snd_ctrl) state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (timeout_hit) state_d = S_IDLE;
        else if (snd_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      tx_src_q  <= '0;
      tx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      tx_src_q  <= tx_src_d;
      tx_data_q <= tx_data_d;
      done_q    <= done_d;
    end
  end

  assign snd_start = (state_q == S_START);
  assign busy      = (state_q != S_IDLE);
  assign tx_data   = tx_data_q;
  assign tx_src    = tx_src_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
module tb_cdc_tx_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  req_grant;
  logic [NR-1:0]  req_done;
  logic           snd_ready;
  logic           snd_ctrl;
  logic           snd_start;
  logic [DW-1:0]  tx_data;
  logic [1:0]     tx_src;
  logic           busy;
  logic           err_timeout;

  int passed = 0;
  int total  = 0;

  cdc_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data),
    .req_grant(req_grant), .req_done(req_done),
    .snd_ready(snd_ready), .snd_ctrl(snd_ctrl), .snd_start(snd_start),
    .tx_data(tx_data), .tx_src(tx_src),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after posedge; outputs are read on negedge.
  task automatic do_reset();
    reset = 1'b1; req_valid = '0; snd_ready = 1'b1; snd_ctrl = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  // Sender model driven from the grant cycle's negedge: takes start at once,
  // acks after ack_dly WAIT_ACK cycles, returns ready one cycle later. Only
  // records observations; the callers compare them.
  task automatic handshake(input logic [NR-1:0] nv, input int ack_dly,
                           output int n_start, output logic [DW-1:0] d0,
                           output logic [1:0] s0, output logic stable,
                           output logic [NR-1:0] done_mid, output logic [NR-1:0] done_v,
                           output logic [NR-1:0] g_done, output logic busy_after);
    next_cyc(); req_valid = nv; snd_ready = 1'b0;
    @(negedge clk);
    d0 = tx_data; s0 = tx_src; n_start = snd_start ? 1 : 0;
    stable = 1'b1; done_mid = req_done;
    for (int i = 0; i < ack_dly + 2; i++) begin
      next_cyc();
      snd_ctrl = (i == ack_dly);
      if (i == ack_dly + 1) snd_ready = 1'b1;
      @(negedge clk);
      if (snd_start) n_start++;
      if (tx_data !== d0 || tx_src !== s0) stable = 1'b0;
      done_mid |= req_done;
    end
    next_cyc();
    @(negedge clk);
    done_v = req_done; g_done = req_grant; busy_after = busy;
    if (tx_data !== d0) stable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_data = '0; snd_ready = 1'b1; snd_ctrl = 1'b0;
    next_cyc(); @(negedge clk);
    total++; if ({req_grant, req_done, snd_start, busy, err_timeout} !== '0)
      $display("FAIL reset_ctrl: got grant=%b done=%b start=%b busy=%b err=%b want all 0",
               req_grant, req_done, snd_start, busy, err_timeout); else passed++;
    total++; if (tx_data !== 8'h00 || tx_src !== 2'd0)
      $display("FAIL reset_tx: got data=%h src=%0d want 00/0", tx_data, tx_src); else passed++;
  endtask

  task automatic test_single();
    int n; logic [DW-1:0] d; logic [1:0] s; logic st, ba; logic [NR-1:0] dm, dv, gd;
    do_reset();
    req_data = 32'h0000_00A5; req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_grant !== 4'b0001) $display("FAIL single_grant: got %b want 0001", req_grant); else passed++;
    handshake(4'b0000, 6, n, d, s, st, dm, dv, gd, ba);
    total++; if (n !== 1) $display("FAIL single_start_len: got %0d want 1", n); else passed++;
    total++; if (d !== 8'hA5 || s !== 2'd0) $display("FAIL single_data: got %h/%0d want a5/0", d, s); else passed++;
    total++; if (!st) $display("FAIL single_stable: got unstable want stable"); else passed++;
    total++; if (dm !== 4'b0000) $display("FAIL single_early_done: got %b want 0000", dm); else passed++;
    total++; if (dv !== 4'b0001) $display("FAIL single_done: got %b want 0001", dv); else passed++;
    next_cyc(); @(negedge clk);
    total++; if (busy !== 1'b0 || req_done !== 4'b0000)
      $display("FAIL single_after: got busy=%b done=%b want 0/0000", busy, req_done); else passed++;
  endtask

  task automatic test_round_robin();
    int n, e; logic [DW-1:0] d, ed; logic [1:0] s; logic st, ba; logic [NR-1:0] dm, dv, gd;
    do_reset();
    req_data = 32'h4332_2110; req_valid = 4'b1111;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      e = k % 4; ed = 8'h10 + 8'(e * 17);
      total++; if (req_grant !== 4'(1 << e)) $display("FAIL rr_grant%0d: got %b want %b", k, req_grant, 4'(1 << e)); else passed++;
      handshake(4'b1111, 2, n, d, s, st, dm, dv, gd, ba);
      total++; if (d !== ed || s !== 2'(e) || !st || n !== 1)
        $display("FAIL rr_xfer%0d: got data=%h src=%0d stable=%b starts=%0d want %h/%0d/1/1", k, d, s, st, n, ed, e); else passed++;
      total++; if (dv !== 4'(1 << e) || gd !== 4'b0000 || ba !== 1'b0)
        $display("FAIL rr_done%0d: got done=%b grant=%b busy=%b want %b/0000/0", k, dv, gd, ba, 4'(1 << e)); else passed++;
      if (k < 4) begin next_cyc(); @(negedge clk); end
    end
    next_cyc(); req_valid = '0;
  endtask

  task automatic test_wrap();
    int n; logic [DW-1:0] d; logic [1:0] s; logic st, ba; logic [NR-1:0] dm, dv, gd;
    do_reset();
    req_data = 32'h0000_BB11; req_valid = 4'b0010;
    @(negedge clk);
    total++; if (req_grant !== 4'b0010) $display("FAIL wrap_g1: got %b want 0010", req_grant); else passed++;
    handshake(4'b0011, 1, n, d, s, st, dm, dv, gd, ba);
    total++; if (dv !== 4'b0010 || d !== 8'hBB) $display("FAIL wrap_d1: got %b/%h want 0010/bb", dv, d); else passed++;
    next_cyc(); @(negedge clk);
    total++; if (req_grant !== 4'b0001) $display("FAIL wrap_g0: got %b want 0001", req_grant); else passed++;
    handshake(4'b0011, 1, n, d, s, st, dm, dv, gd, ba);
    total++; if (dv !== 4'b0001 || d !== 8'h11) $display("FAIL wrap_d0: got %b/%h want 0001/11", dv, d); else passed++;
    next_cyc(); @(negedge clk);
    total++; if (req_grant !== 4'b0010) $display("FAIL wrap_g1b: got %b want 0010", req_grant); else passed++;
    handshake(4'b0000, 1, n, d, s, st, dm, dv, gd, ba);
  endtask

  task automatic test_not_ready();
    int n, bad; logic [DW-1:0] d; logic [1:0] s; logic st, ba; logic [NR-1:0] dm, dv, gd;
    do_reset();
    req_data = 32'h00C3_0000; snd_ready = 1'b0; req_valid = 4'b0100; bad = 0;
    for (int i = 0; i < 5; i++) begin
      snd_ctrl = i[0];  // stray acks in IDLE must be ignored
      @(negedge clk);
      if (req_grant !== 4'b0000 || snd_start !== 1'b0 || busy !== 1'b0) bad++;
      next_cyc();
    end
    snd_ctrl = 1'b0;
    total++; if (bad !== 0) $display("FAIL nrdy_hold: got %0d bad cycles want 0", bad); else passed++;
    snd_ready = 1'b1;
    @(negedge clk);
    total++; if (req_grant !== 4'b0100) $display("FAIL nrdy_grant: got %b want 0100", req_grant); else passed++;
    handshake(4'b0000, 1, n, d, s, st, dm, dv, gd, ba);
    total++; if (dv !== 4'b0100 || d !== 8'hC3 || s !== 2'd2)
      $display("FAIL nrdy_done: got %b/%h/%0d want 0100/c3/2", dv, d, s); else passed++;
  endtask

  task automatic test_reset_mid();
    int dn;
    do_reset();
    req_data = 32'h5A00_0000; req_valid = 4'b1000;
    @(negedge clk);
    total++; if (req_grant !== 4'b1000) $display("FAIL rmid_grant: got %b want 1000", req_grant); else passed++;
    next_cyc(); req_valid = '0; snd_ready = 1'b0;   // START
    next_cyc();                                       // WAIT_ACK
    @(negedge clk);
    total++; if (busy !== 1'b1 || tx_src !== 2'd3 || tx_data !== 8'h5A)
      $display("FAIL rmid_wait: got busy=%b src=%0d data=%h want 1/3/5a", busy, tx_src, tx_data); else passed++;
    next_cyc(); reset = 1'b1; snd_ready = 1'b1;
    next_cyc(); reset = 1'b0;
    @(negedge clk);
    total++; if ({req_grant, req_done, snd_start, busy, err_timeout} !== '0 || tx_data !== 8'h00 || tx_src !== 2'd0)
      $display("FAIL rmid_zero: got grant=%b done=%b start=%b busy=%b data=%h src=%0d want zeros",
               req_grant, req_done, snd_start, busy, tx_data, tx_src); else passed++;
    dn = 0;
    for (int i = 0; i < 3; i++) begin next_cyc(); @(negedge clk); if (req_done !== 4'b0000) dn++; end
    total++; if (dn !== 0) $display("FAIL rmid_nodone: got %0d done pulses want 0", dn); else passed++;
    next_cyc(); req_valid = 4'b1001;
    @(negedge clk);
    total++; if (req_grant !== 4'b0001) $display("FAIL rmid_ptr: got %b want 0001", req_grant); else passed++;
    next_cyc(); req_valid = '0;
    next_cyc();
    do_reset();
  endtask

  task automatic test_timeout();
    int nb; logic [NR-1:0] dn;
    do_reset();
    req_data = 32'h0000_0077; req_valid = 4'b0001;
    @(negedge clk);
    total++; if (req_grant !== 4'b0001) $display("FAIL to_grant: got %b want 0001", req_grant); else passed++;
    next_cyc(); req_valid = '0; snd_ready = 1'b0;    // sender stuck, never acks
    nb = 0; dn = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) nb++;
      dn |= req_done;
      next_cyc();
    end
    @(negedge clk);
`ifdef CDC_TX_ARB_TIMEOUT_EN
    total++; if (nb !== TO + 1) $display("FAIL to_len: got %0d busy cycles want %0d", nb, TO + 1); else passed++;
    total++; if (err_timeout !== 1'b1 || busy !== 1'b0 || dn !== 4'b0000)
      $display("FAIL to_state: got err=%b busy=%b done=%b want 1/0/0000", err_timeout, busy, dn); else passed++;
    next_cyc(); req_valid = 4'b0010;
    @(negedge clk);
    total++; if (req_grant !== 4'b0000) $display("FAIL to_nrdy: got %b want 0000", req_grant); else passed++;
    next_cyc(); snd_ready = 1'b1;
    @(negedge clk);
    total++; if (req_grant !== 4'b0010 || err_timeout !== 1'b1)
      $display("FAIL to_regrant: got %b err=%b want 0010/1", req_grant, err_timeout); else passed++;
`else
    total++; if (nb !== 40) $display("FAIL to_len: got %0d busy cycles want 40", nb); else passed++;
    total++; if (err_timeout !== 1'b0 || busy !== 1'b1 || dn !== 4'b0000)
      $display("FAIL to_state: got err=%b busy=%b done=%b want 0/1/0000", err_timeout, busy, dn); else passed++;
`endif
    do_reset();
    @(negedge clk);
    total++; if (err_timeout !== 1'b0 || busy !== 1'b0)
      $display("FAIL to_clear: got err=%b busy=%b want 0/0", err_timeout, busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_not_ready();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
